// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multiply/divide sequencer owning HI/LO with fixed multi-cycle latency
module md_sequencer #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  E_md_op,
   input  logic [31:0] E_rs,
   input  logic [31:0] E_rt,
   input  logic [1:0]  E_mf_sel,
   input  logic        D_md_use,
   output logic [31:0] E_md_out,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(NMAX + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [31:0]   hi_tmp;
   logic [31:0]   lo_tmp;
   logic          skip_wb;

   logic          start;
   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic          a_neg;
   logic          b_neg;
   logic [31:0]   a_mag;
   logic [31:0]   b_mag;
   logic [31:0]   q_mag;
   logic [31:0]   r_mag;
   logic [31:0]   quot;
   logic [31:0]   rem;

   assign start    = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU);
   assign stall_md = D_md_use & (busy | start);

   always_comb begin
      case (E_mf_sel)
         2'd1:    E_md_out = HI;
         2'd2:    E_md_out = LO;
         default: E_md_out = 32'd0;
      endcase
   end

   // Low 64 bits of the product of sign-extended operands equal the signed product.
   assign prod_s = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
   assign prod_u = {32'd0, E_rs} * {32'd0, E_rt};

   // Signed division on magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
   assign a_neg = (E_md_op == OP_DIV) & E_rs[31];
   assign b_neg = (E_md_op == OP_DIV) & E_rt[31];
   assign a_mag = a_neg ? (~E_rs + 32'd1) : E_rs;
   assign b_mag = b_neg ? (~E_rt + 32'd1) : E_rt;
   assign q_mag = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
   assign r_mag = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
   assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
   assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         count   <= '0;
         busy    <= 1'b0;
         HI      <= 32'd0;
         LO      <= 32'd0;
         hi_tmp  <= 32'd0;
         lo_tmp  <= 32'd0;
         skip_wb <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               case (E_md_op)
                  OP_MULT, OP_MULTU: begin
                     {hi_tmp, lo_tmp} <= (E_md_op == OP_MULT) ? prod_s : prod_u;
                     skip_wb <= 1'b0;
                     count   <= CW'(MULT_CYCLES);
                     busy    <= 1'b1;
                     state   <= RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     hi_tmp  <= rem;
                     lo_tmp  <= quot;
                     skip_wb <= (E_rt == 32'd0);
                     count   <= CW'(DIV_CYCLES);
                     busy    <= 1'b1;
                     state   <= RUN;
                  end
                  OP_MTHI: HI <= E_rs;
                  OP_MTLO: LO <= E_rs;
                  default: ;
               endcase
            end
            RUN: begin
               if (count == CW'(1)) begin
                  if (!skip_wb) begin
                     HI <= hi_tmp;
                     LO <= lo_tmp;
                  end
                  count <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - self-checking bench for md_sequencer against an arithmetic reference model
module tb_md_sequencer;

   localparam logic [2:0] NONE  = 3'd0;
   localparam logic [2:0] MULT  = 3'd1;
   localparam logic [2:0] MULTU = 3'd2;
   localparam logic [2:0] DIV   = 3'd3;
   localparam logic [2:0] DIVU  = 3'd4;
   localparam logic [2:0] MTHI  = 3'd5;
   localparam logic [2:0] MTLO  = 3'd6;
   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  E_md_op;
   logic [31:0] E_rs;
   logic [31:0] E_rt;
   logic [1:0]  E_mf_sel;
   logic        D_md_use;
   logic [31:0] E_md_out;
   logic        busy;
   logic        stall_md;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   md_sequencer #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_rs(E_rs), .E_rt(E_rt),
      .E_mf_sel(E_mf_sel), .D_md_use(D_md_use), .E_md_out(E_md_out),
      .busy(busy), .stall_md(stall_md), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs after the falling edge; outputs are then sampled mid-cycle.
   task automatic step(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [1:0] mf, input logic duse);
      @(negedge clk);
      E_md_op = op; E_rs = rs; E_rt = rt; E_mf_sel = mf; D_md_use = duse;
      #1;
   endtask

   function automatic int ncyc(input logic [2:0] op);
      return (op == DIV || op == DIVU) ? DIV_N : MULT_N;
   endfunction

   task automatic model(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
      longint a, b, p;
      longint unsigned ua, ub, up;
      a = longint'($signed(rs));
      b = longint'($signed(rt));
      ua = {32'd0, rs};
      ub = {32'd0, rt};
      case (op)
         MULT:  begin p = a * b; m_hi = p[63:32]; m_lo = p[31:0]; end
         MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
         DIV:   if (rt != 32'd0) begin
                   p = a / b; m_lo = p[31:0];
                   p = a % b; m_hi = p[31:0];
                end
         DIVU:  if (rt != 32'd0) begin
                   up = ua / ub; m_lo = up[31:0];
                   up = ua % ub; m_hi = up[31:0];
                end
         MTHI:  m_hi = rs;
         MTLO:  m_lo = rs;
         default: ;
      endcase
   endtask

   // Start cycle (unless already issued) plus N busy cycles, optionally injecting a stray op mid-run.
   task automatic run(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [2:0] mid_op, input bit chained, input string tag);
      int n;
      n = ncyc(op);
      if (!chained) begin
         step(op, rs, rt, 2'd0, 1'b1);
         chk({tag, "_start_stall"}, {31'd0, stall_md}, 32'd1);
         chk({tag, "_start_busy"}, {31'd0, busy}, 32'd0);
      end
      model(op, rs, rt);
      for (int i = 1; i <= n; i++) begin
         step((i == 2) ? mid_op : NONE, 32'h0BAD_F00D, 32'h1357_9BDF, 2'd0, 1'b1);
         chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
         chk({tag, "_stall"}, {31'd0, stall_md}, 32'd1);
      end
   endtask

   task automatic idle_check(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input string tag);
      step(op, rs, rt, 2'd0, 1'b0);
      chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hi"}, HI, m_hi);
      chk({tag, "_lo"}, LO, m_lo);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      reset = 1'b0;
      step(NONE, 32'd0, 32'd0, 2'd0, 1'b1);
      step(NONE, 32'd0, 32'd0, 2'd0, 1'b1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      chk("rst_stall_idle", {31'd0, stall_md}, 32'd0);
      reset = 1'b1;

      run(MULT, 32'hFFFF_FFFD, 32'd7, NONE, 1'b0, "mult");
      idle_check(NONE, 32'd0, 32'd0, "mult");
      chk("mult_hi_const", HI, 32'hFFFF_FFFF);
      chk("mult_lo_const", LO, 32'hFFFF_FFEB);

      run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NONE, 1'b0, "multu");
      idle_check(NONE, 32'd0, 32'd0, "multu");
      chk("multu_hi_const", HI, 32'hFFFF_FFFE);
      chk("multu_lo_const", LO, 32'h0000_0001);

      run(DIV, 32'hFFFF_FFF9, 32'd2, NONE, 1'b0, "div");
      idle_check(NONE, 32'd0, 32'd0, "div");
      chk("div_lo_const", LO, 32'hFFFF_FFFD);
      chk("div_hi_const", HI, 32'hFFFF_FFFF);

      run(DIVU, 32'd7, 32'd2, NONE, 1'b0, "divu");
      idle_check(NONE, 32'd0, 32'd0, "divu");
      chk("divu_lo_const", LO, 32'd3);
      chk("divu_hi_const", HI, 32'd1);

      run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, NONE, 1'b0, "div_ovf");
      idle_check(NONE, 32'd0, 32'd0, "div_ovf");
      chk("div_ovf_lo_const", LO, 32'h8000_0000);
      chk("div_ovf_hi_const", HI, 32'd0);

      run(MULT, 32'd6, 32'd7, NONE, 1'b0, "pre_dz");
      idle_check(NONE, 32'd0, 32'd0, "pre_dz");
      run(DIV, 32'd99, 32'd0, NONE, 1'b0, "divzero");
      idle_check(NONE, 32'd0, 32'd0, "divzero");
      chk("divzero_lo_kept", LO, 32'd42);

      step(NONE, 32'd0, 32'd0, 2'd0, 1'b1);
      chk("idle_no_stall", {31'd0, stall_md}, 32'd0);
      step(7, 32'hFFFF_0000, 32'd5, 2'd0, 1'b1);
      chk("reserved_no_stall", {31'd0, stall_md}, 32'd0);
      step(NONE, 32'd0, 32'd0, 2'd0, 1'b0);
      chk("reserved_busy", {31'd0, busy}, 32'd0);
      chk("reserved_hi", HI, m_hi);

      step(MTHI, 32'h0000_1234, 32'd0, 2'd0, 1'b0);
      model(MTHI, 32'h0000_1234, 32'd0);
      step(MTLO, 32'hCAFE_0001, 32'd0, 2'd0, 1'b0);
      chk("mthi_hi", HI, 32'h0000_1234);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      model(MTLO, 32'hCAFE_0001, 32'd0);
      step(NONE, 32'd0, 32'd0, 2'd1, 1'b0);
      chk("mtlo_lo", LO, 32'hCAFE_0001);
      chk("mfhi_out", E_md_out, 32'h0000_1234);
      step(NONE, 32'd0, 32'd0, 2'd2, 1'b0);
      chk("mflo_out", E_md_out, 32'hCAFE_0001);
      step(NONE, 32'd0, 32'd0, 2'd0, 1'b0);
      chk("mfnone_out", E_md_out, 32'd0);
      step(NONE, 32'd0, 32'd0, 2'd3, 1'b0);
      chk("mf3_out", E_md_out, 32'd0);

      run(MULT, 32'd3, 32'd4, MULT, 1'b0, "mid_mult");
      idle_check(NONE, 32'd0, 32'd0, "mid_mult");
      run(DIVU, 32'd100, 32'd9, MTLO, 1'b0, "mid_mtlo");
      idle_check(NONE, 32'd0, 32'd0, "mid_mtlo");

      run(MULT, 32'd11, 32'd13, NONE, 1'b0, "chain_a");
      idle_check(MULTU, 32'h0001_0000, 32'h0001_0000, "chain_a");
      run(MULTU, 32'h0001_0000, 32'h0001_0000, NONE, 1'b1, "chain_b");
      idle_check(NONE, 32'd0, 32'd0, "chain_b");

      step(DIV, 32'd1000, 32'd7, 2'd0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         step(NONE, 32'd0, 32'd0, 2'd0, 1'b0);
         chk("rstrun_busy", {31'd0, busy}, 32'd1);
      end
      reset = 1'b0;
      step(NONE, 32'd0, 32'd0, 2'd0, 1'b0);
      reset = 1'b1;
      m_hi = 32'd0;
      m_lo = 32'd0;
      chk("rstrun_busy_clr", {31'd0, busy}, 32'd0);
      chk("rstrun_hi", HI, 32'd0);
      chk("rstrun_lo", LO, 32'd0);
      for (int i = 0; i < 12; i++) idle_check(NONE, 32'd0, 32'd0, "rstrun_late");

      for (int k = 0; k < 25; k++) begin
         rop = 3'($urandom_range(1, 6));
         ra  = $urandom;
         rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         if (k == 3) begin rop = DIV; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         if (rop == MTHI || rop == MTLO) begin
            step(rop, ra, rb, 2'd0, 1'b0);
            model(rop, ra, rb);
         end else begin
            run(rop, ra, rb, NONE, 1'b0, "rand");
         end
         idle_check(NONE, 32'd0, 32'd0, "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
